// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed 4-digit common-anode 7-segment driver. One digit is lit per
//   refresh slot. Each slot opens with a short all-dark interval so that the
//   previous digit's pattern never ghosts onto the next anode. All four BCD digits
//   are snapshotted together at the end of a scan frame, so one frame never mixes
//   two counter values. The colon (dp of the minutes-units digit) toggles on each
//   colon_tick pulse.
//
// Ports
//   clk         in   1  system clock
//   reset       in   1  asynchronous reset, active-low
//   secslo      in   4  seconds units, BCD
//   secshi      in   4  seconds tens, BCD
//   minslo      in   4  minutes units, BCD
//   minshi      in   4  minutes tens, BCD
//   colon_tick  in   1  single-cycle 1 Hz pulse, toggles the colon
//   an          out  4  anode enables, active-low, an[i] selects digit i
//   seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal point, active-low
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] secslo,
  input  logic [3:0] secshi,
  input  logic [3:0] minslo,
  input  logic [3:0] minshi,
  input  logic       colon_tick,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLNK = CW'(BLANK_CYCLES);

  logic [CW-1:0]   r_count;
  logic [1:0]      r_idx;
  logic            r_colon;
  logic [3:0][3:0] r_snap;   // [3]=minshi .. [0]=secslo
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic            w_wrap;
  logic            w_blank;
  logic            w_dark;
  logic [3:0]      w_digit;
  logic [6:0]      w_seg_dec;
  logic [3:0]      w_an_nxt;
  logic [6:0]      w_seg_nxt;
  logic            w_dp_nxt;

  assign w_wrap  = (r_count == CNT_LAST);
  assign w_blank = (r_count < CNT_BLNK);
  assign w_digit = r_snap[r_idx];
  // Suppressed leading zero on the minutes-tens digit
  assign w_dark  = LZ_BLANK && (r_idx == 2'd3) && (w_digit == 4'd0);

  always_comb begin
    w_seg_dec = 7'b0111111;  // dash for non-BCD codes
    case (w_digit)
      4'd0: w_seg_dec = 7'b1000000;
      4'd1: w_seg_dec = 7'b1111001;
      4'd2: w_seg_dec = 7'b0100100;
      4'd3: w_seg_dec = 7'b0110000;
      4'd4: w_seg_dec = 7'b0011001;
      4'd5: w_seg_dec = 7'b0010010;
      4'd6: w_seg_dec = 7'b0000010;
      4'd7: w_seg_dec = 7'b1111000;
      4'd8: w_seg_dec = 7'b0000000;
      4'd9: w_seg_dec = 7'b0010000;
      default: w_seg_dec = 7'b0111111;
    endcase
  end

  always_comb begin
    w_an_nxt  = 4'b1111;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if (!w_blank && !w_dark) begin
      w_an_nxt  = ~(4'b0001 << r_idx);
      w_seg_nxt = w_seg_dec;
      w_dp_nxt  = ~(r_colon && (r_idx == 2'd2));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_idx   <= 2'd0;
      r_colon <= 1'b0;
      r_snap  <= '0;
      r_an    <= 4'b1111;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
    end else begin
      if (w_wrap) begin
        r_count <= '0;
        r_idx   <= r_idx + 2'd1;
        // Capture at the very end of the last digit's slot so the next frame is coherent
        if (r_idx == 2'd3) begin
          r_snap <= {minshi, minslo, secshi, secslo};
        end
      end else begin
        r_count <= r_count + 1'b1;
      end
      if (colon_tick) begin
        r_colon <= ~r_colon;
      end
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with a small refresh divider.
// Expected display samples are queued per scan frame and popped one per clock.
module tb_seven_seg_scan_driver;

  logic       clk;
  logic       reset;
  logic [3:0] secslo, secshi, minslo, minshi;
  logic       colon_tick;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       an_only;
  } exp_t;

  exp_t  q_exp[$];
  string q_tag[$];

  seven_seg_scan_driver #(
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2),
    .LZ_BLANK    (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .secslo    (secslo),
    .secshi    (secshi),
    .minslo    (minslo),
    .minshi    (minshi),
    .colon_tick(colon_tick),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic push_one(input string tag, input logic [3:0] a, input logic [6:0] s,
                          input logic d, input logic ao);
    exp_t e;
    e.an      = a;
    e.seg     = s;
    e.dp      = d;
    e.an_only = ao;
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask

  // Two blank samples followed by nact samples of the digit window
  task automatic push_win(input string tag, input int idx, input logic [3:0] digit,
                          input bit colon, input int nact);
    logic [3:0] sel;
    case (idx)
      0:       sel = 4'b1110;
      1:       sel = 4'b1101;
      2:       sel = 4'b1011;
      default: sel = 4'b0111;
    endcase
    for (int i = 0; i < 2; i++) push_one(tag, 4'b1111, 7'h7F, 1'b1, 1'b0);
    for (int i = 0; i < nact; i++) begin
      if (idx == 3 && digit == 4'd0)
        push_one(tag, 4'b1111, 7'h7F, 1'b1, 1'b1);
      else
        push_one(tag, sel, seg_of(digit), !(idx == 2 && colon), 1'b0);
    end
  endtask

  task automatic push_frame(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3, input bit colon);
    push_win(tag, 0, d0, colon, 6);
    push_win(tag, 1, d1, colon, 6);
    push_win(tag, 2, d2, colon, 6);
    push_win(tag, 3, d3, colon, 6);
  endtask

  task automatic drain(input int n);
    exp_t  e;
    string t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_total++;
      if (q_exp.size() == 0) begin
        n_bad++;
        $error("FAIL scoreboard_empty: observed an=%b seg=%b dp=%b expected a queued entry", an, seg, dp);
      end else begin
        e = q_exp.pop_front();
        t = q_tag.pop_front();
        if (e.an_only) begin
          assert (an === e.an) else begin
            n_bad++;
            $error("FAIL %s: observed an=%b expected an=%b", t, an, e.an);
          end
        end else begin
          assert ({an, seg, dp} === {e.an, e.seg, e.dp}) else begin
            n_bad++;
            $error("FAIL %s: observed an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   t, an, seg, dp, e.an, e.seg, e.dp);
          end
        end
      end
    end
  endtask

  task automatic check_rst(input string tag);
    n_total++;
    assert (an === 4'b1111) else begin
      n_bad++;
      $error("FAIL %s_an: observed %b expected 1111", tag, an);
    end
    n_total++;
    assert (seg === 7'h7F) else begin
      n_bad++;
      $error("FAIL %s_seg: observed %b expected 1111111", tag, seg);
    end
    n_total++;
    assert (dp === 1'b1) else begin
      n_bad++;
      $error("FAIL %s_dp: observed %b expected 1", tag, dp);
    end
  endtask

  initial begin
    reset      = 1'b0;
    colon_tick = 1'b0;
    secslo = 4'd0; secshi = 4'd0; minslo = 4'd0; minshi = 4'd0;

    // Reset held with random inputs and ticks
    for (int i = 0; i < 4; i++) begin
      secslo     = 4'($urandom_range(0, 15));
      secshi     = 4'($urandom_range(0, 15));
      minslo     = 4'($urandom_range(0, 15));
      minshi     = 4'($urandom_range(0, 15));
      colon_tick = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_rst("reset_hold");
    end

    colon_tick = 1'b0;
    secslo = 4'd9; secshi = 4'd5; minslo = 4'd3; minshi = 4'd1;
    reset  = 1'b1;

    // Frame 0 still shows the reset snapshot
    push_frame("first_frame_zero", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    drain(32);

    push_frame("scan_order", 4'd9, 4'd5, 4'd3, 4'd1, 1'b0);
    drain(32);

    // secslo changes during idx1; this frame keeps the old snapshot
    push_frame("tear_free", 4'd9, 4'd5, 4'd3, 4'd1, 1'b0);
    drain(11);
    secslo = 4'd4;
    drain(21);

    push_frame("new_snap", 4'd4, 4'd5, 4'd3, 4'd1, 1'b0);
    drain(16);
    minshi = 4'd0;
    drain(16);

    push_frame("lead_zero", 4'd4, 4'd5, 4'd3, 4'd0, 1'b0);
    drain(16);
    minshi = 4'hC;
    drain(16);

    // Single colon pulse early in the frame
    push_frame("colon_on", 4'd4, 4'd5, 4'd3, 4'hC, 1'b1);
    drain(2);
    colon_tick = 1'b1;
    drain(1);
    colon_tick = 1'b0;
    drain(29);

    // Second pulse after the idx2 window turns the colon off
    push_frame("colon_hold", 4'd4, 4'd5, 4'd3, 4'hC, 1'b1);
    drain(26);
    colon_tick = 1'b1;
    drain(1);
    colon_tick = 1'b0;
    drain(5);

    // Back-to-back pulses toggle twice; then one more pulse in idx3
    push_frame("colon_b2b", 4'd4, 4'd5, 4'd3, 4'hC, 1'b0);
    drain(2);
    colon_tick = 1'b1;
    drain(2);
    colon_tick = 1'b0;
    drain(22);
    colon_tick = 1'b1;
    drain(1);
    colon_tick = 1'b0;
    drain(5);

    // Partial frame with colon lit, then async reset inside idx2 window
    push_win("pre_rst", 0, 4'd4, 1'b1, 6);
    push_win("pre_rst", 1, 4'd5, 1'b1, 6);
    push_win("pre_rst", 2, 4'd3, 1'b1, 3);
    drain(21);
    #2 reset = 1'b0;
    #1 check_rst("async_rst");
    @(negedge clk);
    check_rst("async_rst_hold");
    reset = 1'b1;

    push_frame("post_rst_zero", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    drain(32);

    push_frame("post_rst_snap", 4'd4, 4'd5, 4'd3, 4'hC, 1'b0);
    drain(32);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
